// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux select arbiter.
// Optional stats port is enabled by MUX_SEL_ARBITER_STATS_EN.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam int unsigned HOLD_CYCLES_DEF = 4;
   localparam int unsigned STATS_W         = 16;

   function automatic logic [1:0] state_grant(arb_state_e s);
      logic [1:0] g;
      g = 2'b00;
      if (s == GNT0) g = 2'b01;
      if (s == GNT1) g = 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_hold_counter.sv
// Grant hold-window counter; expired flags the last cycle of a window.
// Count clears on clr and never wraps past HOLD_CYCLES-1.
module arb_hold_counter
   import mux_arb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int unsigned CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && cnt_q != LAST_CNT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin 2-source arbiter driving a registered mux select.
// MUX_SEL_ARBITER_STATS_EN adds a saturating direct-switch counter.
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       last,
   output logic       sel,
   output logic [1:0] grant,
   output logic       busy
`ifdef MUX_SEL_ARBITER_STATS_EN
   ,
   output logic [STATS_W-1:0] switch_count
`endif
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       ptr_q;
   logic       ptr_d;
   logic [1:0] grant_q;
   logic       sel_q;
   logic       busy_q;

   logic in_gnt;
   logic cur;
   logic oth;
   logic expired;
   logic rel;

   assign in_gnt = (state_q == GNT0) || (state_q == GNT1);
   assign cur    = (state_q == GNT1);
   assign oth    = ~cur;
   assign rel    = in_gnt & (~req[cur] | last | expired);

   arb_hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_hold (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (rel | ~in_gnt),
      .en      (in_gnt & ~rel),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (req == 2'b11) begin
               state_d = ptr_q ? GNT1 : GNT0;
            end else if (req[0]) begin
               state_d = GNT0;
            end else if (req[1]) begin
               state_d = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (rel) begin
               ptr_d = oth;
               if (req[oth]) begin
                  state_d = oth ? GNT1 : GNT0;
               end else if (req[cur] && !last && expired) begin
                  // hold window ran out with no contender: fresh window
                  state_d = state_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         grant_q <= 2'b00;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= state_grant(state_d);
         busy_q  <= (state_d != IDLE);
         // sel keeps its last value through IDLE so the mux never glitches
         if (state_d == GNT0) sel_q <= 1'b0;
         if (state_d == GNT1) sel_q <= 1'b1;
      end
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = busy_q;

`ifdef MUX_SEL_ARBITER_STATS_EN
   logic [STATS_W-1:0] sw_cnt_q;
   logic               sw_hit;

   assign sw_hit = rel & req[oth];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_cnt_q <= '0;
      end else if (sw_hit && sw_cnt_q != '1) begin
         sw_cnt_q <= sw_cnt_q + 1'b1;
      end
   end

   assign switch_count = sw_cnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Table-driven bench for mux_sel_arbiter with an expected-value queue.
// Stats checks run only when MUX_SEL_ARBITER_STATS_EN is defined.
module tb_mux_sel_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic       last;
   logic       sel0, busy0, sel1, busy1;
   logic [1:0] grant0, grant1;
`ifdef MUX_SEL_ARBITER_STATS_EN
   logic [15:0] swc0, swc1;
`endif

   int total;
   int bad;

   typedef struct {
      logic       rst_n;
      logic [1:0] req;
      logic       last;
      logic [1:0] g;
      logic       s;
   } vec_t;

   typedef struct {
      logic [1:0] g;
      logic       s;
      logic       b;
      int         idx;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];

   mux_sel_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .last  (last),
      .sel   (sel0),
      .grant (grant0),
      .busy  (busy0)
`ifdef MUX_SEL_ARBITER_STATS_EN
      ,
      .switch_count (swc0)
`endif
   );

   mux_sel_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .last  (last),
      .sel   (sel1),
      .grant (grant1),
      .busy  (busy1)
`ifdef MUX_SEL_ARBITER_STATS_EN
      ,
      .switch_count (swc1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx,
                      input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] q,
                      input logic l, input logic [1:0] g, input logic s);
      vec_t v;
      v.rst_n = r; v.req = q; v.last = l; v.g = g; v.s = s;
      vq.push_back(v);
   endtask

   task automatic addn(input int n, input logic [1:0] q,
                       input logic [1:0] g, input logic s);
      for (int i = 0; i < n; i++) add(1'b1, q, 1'b0, g, s);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t e;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      req   = 2'b00;
      last  = 1'b0;

      // reset held with both requesting
      for (int i = 0; i < 3; i++) add(1'b0, 2'b11, 1'b0, 2'b00, 1'b0);
      // contention: 01 x4, 10 x4, 01 x4
      addn(4, 2'b11, 2'b01, 1'b0);
      addn(4, 2'b11, 2'b10, 1'b1);
      addn(4, 2'b11, 2'b01, 1'b0);
      // drop to idle, ptr now favours source 1
      addn(2, 2'b00, 2'b00, 1'b0);
      addn(2, 2'b11, 2'b10, 1'b1);
      // last forces early hand-over
      add(1'b1, 2'b11, 1'b1, 2'b01, 1'b0);
      add(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
      add(1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
      // req drop releases to the other source, then idle
      addn(1, 2'b01, 2'b01, 1'b0);
      addn(1, 2'b00, 2'b00, 1'b0);
      addn(1, 2'b01, 2'b01, 1'b0);
      addn(1, 2'b00, 2'b00, 1'b0);
      addn(1, 2'b10, 2'b10, 1'b1);
      // sel holds 1 through idle
      addn(2, 2'b00, 2'b00, 1'b1);
      // lone requester kept across hold expiry
      addn(10, 2'b10, 2'b10, 1'b1);
      add(1'b1, 2'b10, 1'b1, 2'b00, 1'b1);
      // reset mid-grant at count 2
      addn(3, 2'b10, 2'b10, 1'b1);
      add(1'b0, 2'b10, 1'b0, 2'b00, 1'b0);
      add(1'b1, 2'b11, 1'b0, 2'b01, 1'b0);
      add(1'b1, 2'b11, 1'b1, 2'b10, 1'b1);
      add(1'b1, 2'b11, 1'b0, 2'b10, 1'b1);

      foreach (vq[i]) begin
         rst_n = vq[i].rst_n;
         req   = vq[i].req;
         last  = vq[i].last;
         e.g   = vq[i].g;
         e.s   = vq[i].s;
         e.b   = (vq[i].g != 2'b00);
         e.idx = i;
         sb.push_back(e);
         step();
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty[%0d]: got 0 want 1", i);
         end else begin
            e = sb.pop_front();
            chk("grant", e.idx, {14'd0, grant0}, {14'd0, e.g});
            chk("sel", e.idx, {15'd0, sel0}, {15'd0, e.s});
            chk("busy", e.idx, {15'd0, busy0}, {15'd0, e.b});
         end
      end

      // HOLD_CYCLES=1 instance: strict alternation under contention
      rst_n = 1'b0;
      req   = 2'b11;
      last  = 1'b0;
      step();
      chk("h1_rst", 0, {14'd0, grant1}, 16'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("h1_grant", k, {14'd0, grant1},
             (k % 2 == 0) ? 16'd1 : 16'd2);
         chk("h1_sel", k, {15'd0, sel1}, (k % 2 == 0) ? 16'd0 : 16'd1);
      end
`ifdef MUX_SEL_ARBITER_STATS_EN
      chk("swc19", 0, swc1, 16'd19);
      for (int k = 0; k < 70000; k++) @(posedge clk);
      #1;
      chk("swc_sat", 0, swc1, 16'hFFFF);
      rst_n = 1'b0;
      step();
      chk("swc_rst", 0, swc1, 16'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clk) begin
      if (grant0 == 2'b11 || grant1 == 2'b11) begin
         total++;
         bad++;
         $display("FAIL onehot: got %b/%b want not 11", grant0, grant1);
      end
   end

endmodule
